// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the 5-stage pipeline sequencer: FSM state codes,
// PC select codes, and a packed bundle of the control outputs with
// helper functions that build the standard control patterns.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_DM_WAIT  = 2'd2,
    S_BR_FLUSH = 2'd3
  } state_e;

  localparam logic PC_SEL_SEQ = 1'b0;  // PC + 4
  localparam logic PC_SEL_BR  = 1'b1;  // branch target

  typedef struct packed {
    logic pc_enable;
    logic pc_select_br;
    logic im_abort;
    logic x1_enable;
    logic x1_flush;
    logic x2_enable;
    logic x2_flush;
    logic x3_enable;
    logic x4_enable;
  } ctrl_t;

  // Reset / init pattern: nothing loads, front two stages hold bubbles.
  function automatic ctrl_t ctrl_init();
    ctrl_t c;
    c = '0;
    c.x1_flush = 1'b1;
    c.x2_flush = 1'b1;
    return c;
  endfunction

  // Full freeze while a data-memory access is outstanding.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

  // Normal flow: every stage advances.
  function automatic ctrl_t ctrl_run();
    ctrl_t c;
    c = '0;
    c.pc_enable    = 1'b1;
    c.pc_select_br = PC_SEL_SEQ;
    c.x1_enable    = 1'b1;
    c.x2_enable    = 1'b1;
    c.x3_enable    = 1'b1;
    c.x4_enable    = 1'b1;
    return c;
  endfunction

  // Fetch not ready: PC holds, IF/ID takes a bubble, the rest drains.
  function automatic ctrl_t ctrl_fetch_bubble();
    ctrl_t c;
    c = ctrl_run();
    c.pc_enable = 1'b0;
    c.x1_flush  = 1'b1;
    return c;
  endfunction

  // Per-cycle decision once no DM stall applies: hazard, then branch,
  // then fetch wait, then free run.
  function automatic ctrl_t ctrl_run_rules(logic hazard, logic branch, logic im_ack);
    ctrl_t c;
    c = ctrl_run();
    if (hazard) begin
      c.pc_enable = 1'b0;
      c.x1_enable = 1'b0;
      c.x2_flush  = 1'b1;
    end else if (branch) begin
      c.pc_select_br = PC_SEL_BR;
      c.x1_flush     = 1'b1;
      c.x2_flush     = 1'b1;
      c.im_abort     = !im_ack;
    end else if (!im_ack) begin
      c = ctrl_fetch_bubble();
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Saturating event counter used for pipeline performance statistics.
// Only present when PERF_CNT_EN is defined.
`ifdef PERF_CNT_EN
module pipeline_ctrl_perf_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_WIDTH{1'b1}})) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline sequencer: drives PC and IF/ID, ID/EX, EX/MEM, MEM/WB
// enables/flushes, resolving load-use hazards, taken branches, and
// instruction/data memory waits.
// Optional feature macro: PERF_CNT_EN adds saturating stall/flush counters
// (ports stall_cnt, flush_cnt); without it those ports do not exist.
// o_dbg_state exposes the current FSM state for observation.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int RESET_HOLD = 2
`ifdef PERF_CNT_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 do_hazard,
  input  logic                 do_branch,
  input  logic                 im_ack,
  input  logic                 dm_req,
  input  logic                 dm_ack,
  output logic                 pc_enable,
  output logic                 pc_select_br,
  output logic                 im_abort,
  output logic                 xREG1_enable,
  output logic                 xREG1_flush,
  output logic                 xREG2_enable,
  output logic                 xREG2_flush,
  output logic                 xREG3_enable,
  output logic                 xREG4_enable,
`ifdef PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
`endif
  output logic [1:0]           o_dbg_state
);

  // Init counter runs 0 .. RESET_HOLD-1; a hold of 0 or 1 means one cycle.
  localparam int INIT_W = (RESET_HOLD > 2) ? $clog2(RESET_HOLD) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = (RESET_HOLD > 1) ? INIT_W'(RESET_HOLD - 1) : '0;

  state_e            r_state;
  state_e            w_next_state;
  logic [INIT_W-1:0] r_init_cnt;
  ctrl_t             w_ctrl;
  state_e            w_run_next;

  // State register and post-reset hold counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_INIT && w_next_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + INIT_W'(1);
      end
    end
  end

  // A branch that finds the fetch still busy must wait for the target fetch.
  assign w_run_next = (!do_hazard && do_branch && !im_ack) ? S_BR_FLUSH : S_RUN;

  // Next-state and output decode.
  always_comb begin
    w_ctrl       = ctrl_init();
    w_next_state = r_state;
    case (r_state)
      S_INIT: begin
        if (r_init_cnt == INIT_LAST) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (dm_req && !dm_ack) begin
          w_ctrl       = ctrl_freeze();
          w_next_state = S_DM_WAIT;
        end else begin
          w_ctrl       = ctrl_run_rules(do_hazard, do_branch, im_ack);
          w_next_state = w_run_next;
        end
      end
      S_DM_WAIT: begin
        // Held stages re-present hazard/branch once memory completes.
        if (!dm_ack) begin
          w_ctrl = ctrl_freeze();
        end else begin
          w_ctrl       = ctrl_run_rules(do_hazard, do_branch, im_ack);
          w_next_state = w_run_next;
        end
      end
      S_BR_FLUSH: begin
        // EX holds a bubble here, so do_branch cannot be genuine.
        if (dm_req && !dm_ack) begin
          w_ctrl = ctrl_freeze();
        end else if (im_ack) begin
          w_ctrl       = ctrl_run();
          w_next_state = S_RUN;
        end else begin
          w_ctrl = ctrl_fetch_bubble();
        end
      end
      default: begin
        w_next_state = S_INIT;
      end
    endcase
  end

  assign pc_enable    = w_ctrl.pc_enable;
  assign pc_select_br = w_ctrl.pc_select_br;
  assign im_abort     = w_ctrl.im_abort;
  assign xREG1_enable = w_ctrl.x1_enable;
  assign xREG1_flush  = w_ctrl.x1_flush;
  assign xREG2_enable = w_ctrl.x2_enable;
  assign xREG2_flush  = w_ctrl.x2_flush;
  assign xREG3_enable = w_ctrl.x3_enable;
  assign xREG4_enable = w_ctrl.x4_enable;
  assign o_dbg_state  = r_state;

`ifdef PERF_CNT_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = !w_ctrl.pc_enable && (r_state != S_INIT);
  assign w_flush_inc = w_ctrl.pc_select_br;

  pipeline_ctrl_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

  pipeline_ctrl_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_flush_inc),
    .o_count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed per-cycle vectors, expected control
// word pushed at drive time, compared by a monitor at the falling edge.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int W = 11;

  // Control word order: pc_en, sel_br, abort, x1e, x1f, x2e, x2f, x3e, x4e
  localparam logic [8:0] C_INIT = 9'b000_01_01_00;
  localparam logic [8:0] C_RUN  = 9'b100_10_10_11;
  localparam logic [8:0] C_HAZ  = 9'b000_00_11_11;
  localparam logic [8:0] C_BR   = 9'b110_11_11_11;
  localparam logic [8:0] C_BRAB = 9'b111_11_11_11;
  localparam logic [8:0] C_FBUB = 9'b000_11_10_11;
  localparam logic [8:0] C_FRZ  = 9'b000_00_00_00;

  logic clock;
  logic reset;
  logic do_hazard, do_branch, im_ack, dm_req, dm_ack;
  logic pc_enable, pc_select_br, im_abort;
  logic xREG1_enable, xREG1_flush, xREG2_enable, xREG2_flush;
  logic xREG3_enable, xREG4_enable;
  logic [1:0] o_dbg_state;
`ifdef PERF_CNT_EN
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;
`endif

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks;
  int           n_pass;

  pipeline_ctrl #(
    .RESET_HOLD (2)
`ifdef PERF_CNT_EN
    , .CNT_WIDTH (4)
`endif
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .do_hazard    (do_hazard),
    .do_branch    (do_branch),
    .im_ack       (im_ack),
    .dm_req       (dm_req),
    .dm_ack       (dm_ack),
    .pc_enable    (pc_enable),
    .pc_select_br (pc_select_br),
    .im_abort     (im_abort),
    .xREG1_enable (xREG1_enable),
    .xREG1_flush  (xREG1_flush),
    .xREG2_enable (xREG2_enable),
    .xREG2_flush  (xREG2_flush),
    .xREG3_enable (xREG3_enable),
    .xREG4_enable (xREG4_enable),
`ifdef PERF_CNT_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .o_dbg_state  (o_dbg_state)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", exp_q.size());
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", nm, act, exp);
  endtask

  // Driver: apply one cycle of inputs just after the rising edge and
  // record the control word required for that cycle.
  task automatic step(input logic rst, input logic haz, input logic br, input logic ima,
                      input logic dmr, input logic dma, input logic [8:0] c,
                      input state_e st, input string nm);
    @(posedge clock);
    #1;
    reset     = rst;
    do_hazard = haz;
    do_branch = br;
    im_ack    = ima;
    dm_req    = dmr;
    dm_ack    = dma;
    exp_q.push_back({c, 2'(st)});
    name_q.push_back(nm);
  endtask

  // Monitor: compare the presented control word mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, 32'({pc_enable, pc_select_br, im_abort, xREG1_enable, xREG1_flush,
                     xREG2_enable, xREG2_flush, xREG3_enable, xREG4_enable, o_dbg_state}),
            32'(e));
    end
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    do_hazard = 1'b0;
    do_branch = 1'b0;
    im_ack    = 1'b1;
    dm_req    = 1'b0;
    dm_ack    = 1'b1;

    // Reset and hold period
    step(1, 0, 0, 1, 0, 1, C_INIT, S_INIT, "reset_held");
    step(0, 1, 1, 0, 1, 0, C_INIT, S_INIT, "init_hold0_ignores_inputs");
    step(0, 0, 0, 1, 0, 1, C_INIT, S_INIT, "init_hold1");
    step(0, 0, 0, 1, 0, 1, C_RUN,  S_RUN,  "run_first");
    step(0, 0, 0, 1, 0, 1, C_RUN,  S_RUN,  "run_second");

    // Load-use hazard: one bubble, then free flow
    step(0, 1, 0, 1, 0, 1, C_HAZ, S_RUN, "hazard");
    step(0, 0, 0, 1, 0, 1, C_RUN, S_RUN, "after_hazard");

    // Branch with fetch complete
    step(0, 0, 1, 1, 0, 1, C_BR,  S_RUN, "branch_im_ack");
    step(0, 0, 0, 1, 0, 1, C_RUN, S_RUN, "after_branch");

    // Branch with fetch outstanding: abort, wait 2 cycles, ack on third
    step(0, 0, 1, 0, 0, 1, C_BRAB, S_RUN,      "branch_abort");
    step(0, 0, 0, 0, 0, 1, C_FBUB, S_BR_FLUSH, "br_flush_wait1");
    step(0, 0, 0, 0, 0, 1, C_FBUB, S_BR_FLUSH, "br_flush_wait2");
    step(0, 0, 0, 1, 0, 1, C_RUN,  S_BR_FLUSH, "br_flush_ack");
    step(0, 0, 0, 1, 0, 1, C_RUN,  S_RUN,      "after_br_flush");

    // Fetch wait in run
    step(0, 0, 0, 0, 0, 1, C_FBUB, S_RUN, "fetch_bubble");

    // DM wait 4 cycles with branch pending; branch taken on ack cycle
    step(0, 0, 1, 1, 1, 0, C_FRZ, S_RUN,     "dm_freeze1");
    step(0, 0, 1, 1, 1, 0, C_FRZ, S_DM_WAIT, "dm_freeze2");
    step(0, 0, 1, 1, 1, 0, C_FRZ, S_DM_WAIT, "dm_freeze3");
    step(0, 0, 1, 1, 1, 0, C_FRZ, S_DM_WAIT, "dm_freeze4");
    step(0, 0, 1, 1, 1, 1, C_BR,  S_DM_WAIT, "dm_ack_branch");
    step(0, 0, 0, 1, 0, 1, C_RUN, S_RUN,     "after_dm_wait");

    // Same-cycle DM ack: no stall; hazard beats branch
    step(0, 0, 0, 1, 1, 1, C_RUN, S_RUN, "dm_req_ack_same");
    step(0, 1, 1, 1, 0, 1, C_HAZ, S_RUN, "hazard_over_branch");

    // Hazard resolved on DM ack cycle
    step(0, 0, 0, 1, 1, 0, C_FRZ, S_RUN,     "dm_freeze_h");
    step(0, 1, 0, 1, 1, 1, C_HAZ, S_DM_WAIT, "dm_ack_hazard");

    // DM ack with branch and fetch outstanding lands in BR_FLUSH
    step(0, 0, 0, 1, 1, 0, C_FRZ,  S_RUN,      "dm_freeze_b");
    step(0, 0, 1, 0, 1, 1, C_BRAB, S_DM_WAIT,  "dm_ack_branch_abort");
    step(0, 0, 0, 1, 0, 1, C_RUN,  S_BR_FLUSH, "br_flush_ack_b");

    // DM stall inside BR_FLUSH freezes and stays
    step(0, 0, 1, 0, 0, 1, C_BRAB, S_RUN,      "branch_abort_c");
    step(0, 0, 0, 0, 1, 0, C_FRZ,  S_BR_FLUSH, "br_flush_dm_freeze");
    step(0, 0, 1, 0, 1, 1, C_FBUB, S_BR_FLUSH, "br_flush_branch_ignored");
    step(0, 0, 0, 1, 0, 1, C_RUN,  S_BR_FLUSH, "br_flush_ack_c");
    step(0, 0, 0, 1, 0, 1, C_RUN,  S_RUN,      "after_br_flush_c");

    // Asynchronous reset during DM wait
    step(0, 0, 0, 1, 1, 0, C_FRZ,  S_RUN,     "dm_freeze_r");
    step(0, 0, 0, 1, 1, 0, C_FRZ,  S_DM_WAIT, "dm_wait_r");
    step(1, 0, 1, 1, 1, 0, C_INIT, S_INIT,    "async_reset_in_dm_wait");
    step(0, 0, 0, 1, 0, 1, C_INIT, S_INIT,    "reinit_hold0");
    step(0, 0, 0, 1, 0, 1, C_INIT, S_INIT,    "reinit_hold1");
    step(0, 0, 0, 1, 0, 1, C_RUN,  S_RUN,     "rerun");

`ifdef PERF_CNT_EN
    // 5 fetch stalls + 2 aborted branches each with one wait cycle
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, C_FBUB, S_RUN, "perf_stall");
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 0, 0, 1, C_BRAB, S_RUN,      "perf_branch");
      step(0, 0, 0, 0, 0, 1, C_FBUB, S_BR_FLUSH, "perf_br_wait");
      step(0, 0, 0, 1, 0, 1, C_RUN,  S_BR_FLUSH, "perf_br_ack");
    end
    step(0, 0, 0, 1, 0, 1, C_RUN, S_RUN, "perf_idle");
    #1;
    check("stall_cnt_7", 32'(stall_cnt), 32'd7);
    check("flush_cnt_2", 32'(flush_cnt), 32'd2);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1, C_FBUB, S_RUN, "perf_stall_sat");
    step(0, 0, 0, 1, 0, 1, C_RUN, S_RUN, "perf_idle_sat");
    #1;
    check("stall_cnt_sat", 32'(stall_cnt), 32'd15);
    check("flush_cnt_hold", 32'(flush_cnt), 32'd2);
`endif

    // Drain the monitor
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    @(posedge clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
